tree_adder_sequencer: RTL and testbench



---
 rtl/tree_adder_pkg.sv | 45 ++++
 rtl/tree_adder_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_tree_adder_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tree_adder_pkg.sv
// ----------------------------------------------------------------------------
// tree_adder_pkg
// Shared definitions for the tree adder grid and its command sequencer:
//   - broadcast command codes (also decoded by every grid element)
//   - load-source encoding carried by a reduction request
//   - sequencer state encoding
//   - decim_steps(): number of sum-decimate commands needed to fold a
//     GRID_DIM x GRID_DIM grid into its top-left element after the top load
// ----------------------------------------------------------------------------
package tree_adder_pkg;

    // Command codes broadcast on the grid cmd bus.
    localparam int unsigned CMD_HOLD               = 0;
    localparam int unsigned CMD_TOPLOAD_SHADOW_A   = 9;
    localparam int unsigned CMD_TOPLOAD_SHADOW_B   = 10;
    localparam int unsigned CMD_SUMDECIMATE        = 11;
    localparam int unsigned CMD_TOPLOAD_MULTIPLIER = 12;

    // Width of the optional completed-reduction counter.
    localparam int unsigned STAT_W = 16;

    // Source the grid top row loads from.
    typedef enum logic [1:0] {
        SRC_MULTIPLIER = 2'd0,
        SRC_SHADOW_A   = 2'd1,
        SRC_SHADOW_B   = 2'd2,
        SRC_RESERVED   = 2'd3
    } src_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_DECIM   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

    // The top load already performs the first pairwise fold, so a grid of
    // side 2^n needs n-1 further decimation passes.
    function automatic int decim_steps(input int grid_dim);
        return $clog2(grid_dim) - 1;
    endfunction

endpackage

// File: rtl/tree_adder_sequencer.sv
// ----------------------------------------------------------------------------
// tree_adder_sequencer
// Initiator side of the tree adder command interface. Accepts a reduction
// request, broadcasts one top-load command followed by DECIM_STEPS
// sum-decimate commands to the grid, samples the top-left element's sum as
// the grid total and returns it over a valid/ready handshake.
//
// Optional feature: define TREE_ADDER_SEQ_STATS_EN to add stat_done_count,
// a wrapping count of error-free result handshakes.
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   req_valid       reduction request valid
//   req_ready       sequencer idle and able to accept a request
//   req_src         load source (0 multiplier, 1 shadow A, 2 shadow B, 3 reserved)
//   cmd_out         command broadcast to every grid element
//   corner_sum_in   sumout of the top-left grid element
//   res_valid       result valid
//   res_ready       consumer accepts the result
//   res_data        reduced sum
//   res_err         request carried the reserved source
//   busy            sequencer not idle
//   stat_done_count (TREE_ADDER_SEQ_STATS_EN only) completed good reductions
// ----------------------------------------------------------------------------
module tree_adder_sequencer
    import tree_adder_pkg::*;
#(
    parameter int CMD_WIDTH      = 4,
    parameter int ADDER_DATASIZE = 16,
    parameter int GRID_DIM       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_src,
    output logic [CMD_WIDTH-1:0]      cmd_out,
    input  logic [ADDER_DATASIZE-1:0] corner_sum_in,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ADDER_DATASIZE-1:0] res_data,
    output logic                      res_err,
    output logic                      busy
`ifdef TREE_ADDER_SEQ_STATS_EN
    ,
    output logic [STAT_W-1:0]         stat_done_count
`endif
);

    localparam int DECIM_STEPS = decim_steps(GRID_DIM);
    localparam int STEP_W      = (DECIM_STEPS > 1) ? $clog2(DECIM_STEPS) : 1;
    // Unreachable when DECIM_STEPS = 0 because DECIM is then never entered.
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DECIM_STEPS - 1);

    seq_state_e                state_q, state_d;
    src_e                      src_q, src_d;
    logic [STEP_W-1:0]         step_q, step_d;
    logic [ADDER_DATASIZE-1:0] res_data_q, res_data_d;
    logic                      res_err_q, res_err_d;

`ifdef TREE_ADDER_SEQ_STATS_EN
    logic [STAT_W-1:0]         stat_cnt_q, stat_cnt_d;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        src_d      = src_q;
        step_d     = step_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    src_d = src_e'(req_src);
                    if (src_e'(req_src) == SRC_RESERVED) begin
                        // Reject without touching the grid.
                        state_d    = ST_DONE;
                        res_data_d = '0;
                        res_err_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                step_d  = '0;
                state_d = (DECIM_STEPS > 0) ? ST_DECIM : ST_CAPTURE;
            end
            ST_DECIM: begin
                if (step_q == STEP_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_CAPTURE: begin
                // Grid has settled under HOLD; the corner holds the total.
                res_data_d = corner_sum_in;
                res_err_d  = 1'b0;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef TREE_ADDER_SEQ_STATS_EN
    always_comb begin
        stat_cnt_d = stat_cnt_q;
        if ((state_q == ST_DONE) && res_ready && !res_err_q) begin
            stat_cnt_d = stat_cnt_q + STAT_W'(1);
        end
    end
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_MULTIPLIER;
            step_q     <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
`ifdef TREE_ADDER_SEQ_STATS_EN
            stat_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            step_q     <= step_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
`ifdef TREE_ADDER_SEQ_STATS_EN
            stat_cnt_q <= stat_cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only, so the grid never sees
    // a combinational path from the request or result handshakes.
    // ------------------------------------------------------------------
    always_comb begin
        cmd_out = CMD_WIDTH'(CMD_HOLD);
        unique case (state_q)
            ST_LOAD: begin
                unique case (src_q)
                    SRC_MULTIPLIER: cmd_out = CMD_WIDTH'(CMD_TOPLOAD_MULTIPLIER);
                    SRC_SHADOW_A:   cmd_out = CMD_WIDTH'(CMD_TOPLOAD_SHADOW_A);
                    SRC_SHADOW_B:   cmd_out = CMD_WIDTH'(CMD_TOPLOAD_SHADOW_B);
                    default:        cmd_out = CMD_WIDTH'(CMD_HOLD);
                endcase
            end
            ST_DECIM: cmd_out = CMD_WIDTH'(CMD_SUMDECIMATE);
            default:  cmd_out = CMD_WIDTH'(CMD_HOLD);
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

`ifdef TREE_ADDER_SEQ_STATS_EN
    assign stat_done_count = stat_cnt_q;
`endif

endmodule

// File: tb/tb_tree_adder_sequencer.sv
// ----------------------------------------------------------------------------
// tb_tree_adder_sequencer
// Two sequencer instances: u0 drives an 8x8 grid (two decimation passes),
// u1 a 2x2 grid (none). A timeline model tracks, per instance, how many
// cycles have passed since a request was accepted and derives every output
// from that; one process compares all outputs on every falling edge.
// Directed tasks add literal expectations for the command sequence, result
// latency and result contents. Build with TREE_ADDER_SEQ_STATS_EN to also
// check stat_done_count.
// ----------------------------------------------------------------------------
module tb_tree_adder_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic [1:0]  req_src   [2];
    logic [3:0]  cmd_out   [2];
    logic [15:0] corner    [2];
    logic        res_valid [2];
    logic        res_ready [2];
    logic [15:0] res_data  [2];
    logic        res_err   [2];
    logic        busy      [2];
`ifdef TREE_ADDER_SEQ_STATS_EN
    logic [15:0] stat_cnt  [2];
`endif

    tree_adder_sequencer #(.CMD_WIDTH(4), .ADDER_DATASIZE(16), .GRID_DIM(8)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_src(req_src[0]),
        .cmd_out(cmd_out[0]), .corner_sum_in(corner[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_data(res_data[0]), .res_err(res_err[0]), .busy(busy[0])
`ifdef TREE_ADDER_SEQ_STATS_EN
        , .stat_done_count(stat_cnt[0])
`endif
    );

    tree_adder_sequencer #(.CMD_WIDTH(4), .ADDER_DATASIZE(16), .GRID_DIM(2)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_src(req_src[1]),
        .cmd_out(cmd_out[1]), .corner_sum_in(corner[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_data(res_data[1]), .res_err(res_err[1]), .busy(busy[1])
`ifdef TREE_ADDER_SEQ_STATS_EN
        , .stat_done_count(stat_cnt[1])
`endif
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline model. m_pos = cycles since acceptance (-1 when no command
    // sequence is running): position 0 is the top load, 1..steps are the
    // decimate passes, steps+1 is the settle/capture cycle.
    // ------------------------------------------------------------------
    function automatic int steps_of(input int i);
        return (i == 0) ? 2 : 0;  // log2(8)-1 and log2(2)-1
    endfunction

    function automatic logic [3:0] load_code(input logic [1:0] src);
        case (src)
            2'd0:    return 4'd12;
            2'd1:    return 4'd9;
            2'd2:    return 4'd10;
            default: return 4'd0;
        endcase
    endfunction

    int          m_pos  [2];
    bit          m_done [2];
    bit          m_err  [2];
    logic [1:0]  m_src  [2];
    logic [15:0] m_data [2];
    logic [15:0] m_cnt  [2];
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_pos[i]  <= -1;
                m_done[i] <= 1'b0;
                m_err[i]  <= 1'b0;
                m_src[i]  <= 2'd0;
                m_data[i] <= 16'h0;
                m_cnt[i]  <= 16'h0;
            end else if (m_done[i]) begin
                if (res_ready[i]) begin
                    m_done[i] <= 1'b0;
                    if (!m_err[i]) m_cnt[i] <= m_cnt[i] + 16'd1;
                end
            end else if (m_pos[i] >= 0) begin
                if (m_pos[i] == steps_of(i) + 1) begin
                    m_data[i] <= corner[i];
                    m_err[i]  <= 1'b0;
                    m_done[i] <= 1'b1;
                    m_pos[i]  <= -1;
                end else begin
                    m_pos[i] <= m_pos[i] + 1;
                end
            end else if (req_valid[i]) begin
                m_src[i] <= req_src[i];
                if (req_src[i] == 2'd3) begin
                    m_done[i] <= 1'b1;
                    m_data[i] <= 16'h0;
                    m_err[i]  <= 1'b1;
                end else begin
                    m_pos[i] <= 0;
                end
            end
        end
    end

    function automatic logic [3:0] exp_cmd(input int i);
        if (m_pos[i] == 0) return load_code(m_src[i]);
        if (m_pos[i] >= 1 && m_pos[i] <= steps_of(i)) return 4'd11;
        return 4'd0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                automatic bit idle = (m_pos[i] < 0) && !m_done[i];
                check($sformatf("u%0d.cmd_out", i),   32'(cmd_out[i]),   32'(exp_cmd(i)));
                check($sformatf("u%0d.req_ready", i), 32'(req_ready[i]), 32'(idle));
                check($sformatf("u%0d.busy", i),      32'(busy[i]),      32'(!idle));
                check($sformatf("u%0d.res_valid", i), 32'(res_valid[i]), 32'(m_done[i]));
                check($sformatf("u%0d.res_data", i),  32'(res_data[i]),  32'(m_data[i]));
                check($sformatf("u%0d.res_err", i),   32'(res_err[i]),   32'(m_err[i]));
`ifdef TREE_ADDER_SEQ_STATS_EN
                check($sformatf("u%0d.stat_done_count", i), 32'(stat_cnt[i]), 32'(m_cnt[i]));
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus. Tasks start and end 1 time unit after a rising
    // edge. cmd_log[k] is cmd_out in the k-th cycle after acceptance;
    // lat is the number of edges after acceptance until res_valid is seen.
    // ------------------------------------------------------------------
    logic [3:0] cmd_log [8];
    int         lat;

    task automatic do_req(input int i, input logic [1:0] src, input int bp, input bit early,
                          input logic [15:0] exp_data, input bit exp_err);
        req_valid[i] = 1'b1;
        req_src[i]   = src;
        res_ready[i] = early;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        req_src[i]   = 2'd0;
        lat = -1;
        for (int k = 0; k < 8; k++) cmd_log[k] = 4'hx;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (k <= 8) cmd_log[k-1] = cmd_out[i];
            if (res_valid[i]) lat = k - 1;
        end
        if (lat < 0) check($sformatf("u%0d.res_valid_timeout", i), 32'(res_valid[i]), 32'd1);
        check($sformatf("u%0d.res_data_lit", i), 32'(res_data[i]), 32'(exp_data));
        check($sformatf("u%0d.res_err_lit", i),  32'(res_err[i]),  32'(exp_err));
        // Backpressure: the grid total keeps moving but the result must not.
        for (int b = 0; b < bp; b++) begin
            corner[i] = 16'($urandom);
            @(negedge clk);
            check($sformatf("u%0d.bp_res_data", i),  32'(res_data[i]),  32'(exp_data));
            check($sformatf("u%0d.bp_cmd_out", i),   32'(cmd_out[i]),   32'd0);
            check($sformatf("u%0d.bp_req_ready", i), 32'(req_ready[i]), 32'd0);
            check($sformatf("u%0d.bp_res_valid", i), 32'(res_valid[i]), 32'd1);
        end
        res_ready[i] = 1'b1;
        @(posedge clk); #1;
        res_ready[i] = 1'b0;
        check($sformatf("u%0d.req_ready_after_hs", i), 32'(req_ready[i]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_src[i]   = 2'd0;
            res_ready[i] = 1'b0;
            corner[i]    = 16'h0;
        end
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("u0.reset_req_ready", 32'(req_ready[0]), 32'd1);
        check("u0.reset_cmd_out",   32'(cmd_out[0]),   32'd0);
        check("u0.reset_res_data",  32'(res_data[0]),  32'd0);
        check("u0.reset_busy",      32'(busy[0]),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Multiplier source, 8x8 grid: 12, 11, 11, 0 then result.
        corner[0] = 16'h1234;
        do_req(0, 2'd0, 0, 1'b0, 16'h1234, 1'b0);
        check("t1.cmd0", 32'(cmd_log[0]), 32'd12);
        check("t1.cmd1", 32'(cmd_log[1]), 32'd11);
        check("t1.cmd2", 32'(cmd_log[2]), 32'd11);
        check("t1.cmd3", 32'(cmd_log[3]), 32'd0);
        check("t1.latency", 32'(lat), 32'd4);

        // Shadow B source, 2x2 grid: 10 then HOLD, no decimate.
        corner[1] = 16'hA5C3;
        do_req(1, 2'd2, 0, 1'b0, 16'hA5C3, 1'b0);
        check("t2.cmd0", 32'(cmd_log[0]), 32'd10);
        check("t2.cmd1", 32'(cmd_log[1]), 32'd0);
        check("t2.cmd2", 32'(cmd_log[2]), 32'd0);
        check("t2.latency", 32'(lat), 32'd2);

        // Reserved source: rejected at once, nothing issued.
        corner[0] = 16'h7777;
        do_req(0, 2'd3, 0, 1'b0, 16'h0000, 1'b1);
        check("t3.cmd0", 32'(cmd_log[0]), 32'd0);
        check("t3.latency", 32'(lat), 32'd0);

        // Shadow A source with 5 cycles of result backpressure.
        corner[0] = 16'hBEEF;
        do_req(0, 2'd1, 5, 1'b0, 16'hBEEF, 1'b0);
        check("t4.cmd0", 32'(cmd_log[0]), 32'd9);
        check("t4.cmd1", 32'(cmd_log[1]), 32'd11);
        check("t4.cmd3", 32'(cmd_log[3]), 32'd0);
        check("t4.latency", 32'(lat), 32'd4);

        // Reset during the first decimate cycle; a request on u1 held with
        // reset must be ignored.
        corner[0]    = 16'h5555;
        req_valid[0] = 1'b1;
        req_src[0]   = 2'd0;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst          = 1'b1;
        req_valid[1] = 1'b1;
        req_src[1]   = 2'd1;
        @(negedge clk);
        check("t5.first_decim_cmd", 32'(cmd_out[0]), 32'd11);
        @(posedge clk); #1;
        rst          = 1'b0;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("t5.cmd_out",   32'(cmd_out[0]),   32'd0);
        check("t5.res_valid", 32'(res_valid[0]), 32'd0);
        check("t5.busy",      32'(busy[0]),      32'd0);
        check("t5.req_ready", 32'(req_ready[0]), 32'd1);
        check("t5.u1_busy",   32'(busy[1]),      32'd0);
        repeat (4) @(negedge clk);
        check("t5.no_result", 32'(res_valid[0]), 32'd0);
        @(posedge clk); #1;

        // Three good reductions and one rejected one after a fresh reset;
        // one run holds res_ready high before the result exists.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        corner[0] = 16'hFFFF;
        do_req(0, 2'd0, 0, 1'b1, 16'hFFFF, 1'b0);
        corner[0] = 16'h0001;
        do_req(0, 2'd2, 2, 1'b0, 16'h0001, 1'b0);
        do_req(0, 2'd3, 0, 1'b0, 16'h0000, 1'b1);
        corner[0] = 16'h8000;
        do_req(0, 2'd1, 0, 1'b1, 16'h8000, 1'b0);
        corner[1] = 16'h0F0F;
        do_req(1, 2'd0, 0, 1'b1, 16'h0F0F, 1'b0);
        check("t6.u1_cmd0", 32'(cmd_log[0]), 32'd12);
`ifdef TREE_ADDER_SEQ_STATS_EN
        check("t6.stat_done_count", 32'(stat_cnt[0]), 32'd3);
        check("t6.u1_stat_done_count", 32'(stat_cnt[1]), 32'd1);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
